// File: rtl/mem_stage_lsu_pkg.sv
// mem_stage_lsu_pkg: shared width constant and MEM-stage FSM state encoding
package mem_stage_lsu_pkg;
  localparam int XLEN = 32;
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;
endpackage

// File: rtl/mem_wait_timer.sv
// mem_wait_timer: saturating wait-state counter with clear/enable and expiry flag
module mem_wait_timer #(
  parameter int LIMIT = 15,
  parameter int W = 5
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic exp_o
);
  localparam logic [W-1:0] LIM = W'(LIMIT);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr_i ? '0 : (en_i && cnt_q != LIM) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk) cnt_q <= reset ? '0 : cnt_d;
  assign exp_o = cnt_q == LIM;
endmodule

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: MEM stage with handshaked data bus, timeout abort, branch resolve and MEM/WB register
module mem_stage_lsu import mem_stage_lsu_pkg::*; #(
  parameter int DATA_W = XLEN,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] alu_result_EX_MEM,
  input  logic [DATA_W-1:0] read_data2_EX_MEM,
  input  logic [DATA_W-1:0] add_alu_out_EX_MEM,
  input  logic              z_flag_EX_MEM,
  input  logic              branch_EX_MEM,
  input  logic              memread_EX_MEM,
  input  logic              memwrite_EX_MEM,
  input  logic              memtoreg_EX_MEM,
  input  logic              regwrite_EX_MEM,
  input  logic [4:0]        rd_EX_MEM,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ready,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              stall_mem,
  output logic              pcsrc,
  output logic [DATA_W-1:0] branch_target,
  output logic [DATA_W-1:0] read_data_MEM_WB,
  output logic [DATA_W-1:0] alu_result_MEM_WB,
  output logic              memtoreg_MEM_WB,
  output logic              regwrite_MEM_WB,
  output logic [4:0]        rd_MEM_WB,
  output logic              mem_err
);
  logic [0:0] state_q, state_d;
  logic mem_op, expired, abort, hold;
  logic [DATA_W-1:0] rdata_q, rdata_d, alu_q, alu_d;
  logic [4:0] rd_q, rd_d;
  logic rw_q, rw_d, mtr_q, mtr_d, err_q, err_d;
  assign mem_op = memread_EX_MEM | memwrite_EX_MEM;
  assign dmem_req = ~reset & (state_q == ST_WAIT | mem_op);
  assign dmem_we = memwrite_EX_MEM;
  assign dmem_addr = alu_result_EX_MEM;
  assign dmem_wdata = read_data2_EX_MEM;
  assign abort = state_q == ST_WAIT & ~dmem_ready & expired;
  assign stall_mem = dmem_req & ~dmem_ready & ~abort;
  assign pcsrc = ~reset & branch_EX_MEM & z_flag_EX_MEM;
  assign branch_target = add_alu_out_EX_MEM;
  // Stalled and aborted edges insert a bubble: controls drop, data fields hold.
  assign hold = stall_mem | abort;
  always_comb begin
    state_d = stall_mem ? ST_WAIT : ST_IDLE;
    rw_d = ~hold & regwrite_EX_MEM;
    mtr_d = ~hold & memtoreg_EX_MEM;
    rd_d = hold ? rd_q : rd_EX_MEM;
    alu_d = hold ? alu_q : alu_result_EX_MEM;
    rdata_d = hold ? rdata_q : (memread_EX_MEM & ~memwrite_EX_MEM) ? dmem_rdata : '0;
    err_d = err_q | abort;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      rw_q <= 1'b0;
      mtr_q <= 1'b0;
      rd_q <= '0;
      alu_q <= '0;
      rdata_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rw_q <= rw_d;
      mtr_q <= mtr_d;
      rd_q <= rd_d;
      alu_q <= alu_d;
      rdata_q <= rdata_d;
      err_q <= err_d;
    end
  end
  mem_wait_timer #(.LIMIT(TIMEOUT_CYC - 1), .W($clog2(TIMEOUT_CYC + 1))) u_timer (
    .clk(clk),
    .reset(reset),
    .clr_i(~stall_mem),
    .en_i(stall_mem),
    .exp_o(expired)
  );
  assign read_data_MEM_WB = rdata_q;
  assign alu_result_MEM_WB = alu_q;
  assign memtoreg_MEM_WB = mtr_q;
  assign regwrite_MEM_WB = rw_q;
  assign rd_MEM_WB = rd_q;
  assign mem_err = err_q;
endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb_mem_stage_lsu: randomized scoreboard bench for mem_stage_lsu against a per-instruction reference model
module tb_mem_stage_lsu;
  localparam int TO = 16;
  logic clk = 0, reset = 1;
  logic [31:0] alu_result_EX_MEM = 0, read_data2_EX_MEM = 0, add_alu_out_EX_MEM = 0;
  logic z_flag_EX_MEM = 0, branch_EX_MEM = 0, memread_EX_MEM = 0, memwrite_EX_MEM = 0;
  logic memtoreg_EX_MEM = 0, regwrite_EX_MEM = 0;
  logic [4:0] rd_EX_MEM = 0;
  logic dmem_req, dmem_we, dmem_ready = 0, stall_mem, pcsrc;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata = 0, branch_target;
  logic [31:0] read_data_MEM_WB, alu_result_MEM_WB;
  logic memtoreg_MEM_WB, regwrite_MEM_WB, mem_err;
  logic [4:0] rd_MEM_WB;

  mem_stage_lsu #(.DATA_W(32), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset(reset),
    .alu_result_EX_MEM(alu_result_EX_MEM), .read_data2_EX_MEM(read_data2_EX_MEM),
    .add_alu_out_EX_MEM(add_alu_out_EX_MEM), .z_flag_EX_MEM(z_flag_EX_MEM),
    .branch_EX_MEM(branch_EX_MEM), .memread_EX_MEM(memread_EX_MEM),
    .memwrite_EX_MEM(memwrite_EX_MEM), .memtoreg_EX_MEM(memtoreg_EX_MEM),
    .regwrite_EX_MEM(regwrite_EX_MEM), .rd_EX_MEM(rd_EX_MEM),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata), .stall_mem(stall_mem),
    .pcsrc(pcsrc), .branch_target(branch_target),
    .read_data_MEM_WB(read_data_MEM_WB), .alu_result_MEM_WB(alu_result_MEM_WB),
    .memtoreg_MEM_WB(memtoreg_MEM_WB), .regwrite_MEM_WB(regwrite_MEM_WB),
    .rd_MEM_WB(rd_MEM_WB), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic req, we, pc;
    logic [31:0] addr, wdata, tgt;
    int stalls;
    logic rw, mtr, err;
    logic [4:0] rd;
    logic [31:0] alu, rdata;
  } exp_t;

  exp_t q[$];
  int checks = 0, errors = 0;
  logic m_rw = 0, m_mtr = 0, m_err = 0;
  logic [4:0] m_rd = 0;
  logic [31:0] m_alu = 0, m_rdata = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: an access that sees no ready within TO request cycles is aborted.
  task automatic issue(input logic mr, mw, rw, mtr, br, z, input logic [4:0] rd,
                       input logic [31:0] alu, wd, tgt, rdat, input int lat);
    exp_t e;
    logic mop, ab, s;
    int c;
    mop = mr | mw;
    ab = mop && lat >= TO;
    e.req = mop; e.we = mw; e.pc = br & z;
    e.addr = alu; e.wdata = wd; e.tgt = tgt;
    e.stalls = !mop ? 0 : (lat < TO - 1 ? lat : TO - 1);
    if (ab) begin
      m_rw = 0; m_mtr = 0; m_err = 1;
    end else begin
      m_rw = rw; m_mtr = mtr; m_rd = rd; m_alu = alu;
      m_rdata = (mr && !mw) ? rdat : 32'h0;
    end
    e.rw = m_rw; e.mtr = m_mtr; e.err = m_err; e.rd = m_rd; e.alu = m_alu; e.rdata = m_rdata;
    memread_EX_MEM = mr; memwrite_EX_MEM = mw; regwrite_EX_MEM = rw; memtoreg_EX_MEM = mtr;
    branch_EX_MEM = br; z_flag_EX_MEM = z; rd_EX_MEM = rd;
    alu_result_EX_MEM = alu; read_data2_EX_MEM = wd; add_alu_out_EX_MEM = tgt;
    q.push_back(e);
    c = 0;
    forever begin
      dmem_ready = mop ? (c >= lat) : 1'($urandom);
      dmem_rdata = (mop && c >= lat) ? rdat : $urandom;
      @(negedge clk);
      s = stall_mem;
      @(posedge clk);
      #1;
      if (!s) break;
      c++;
      if (c > 200) begin
        checks++; errors++;
        $display("FAIL issue_timeout: stall still 1 after %0d cycles, required release", c);
        break;
      end
    end
  endtask

  // Monitor: checks bus/branch outputs every cycle and MEM/WB after each retirement.
  int stall_cnt = 0;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset || q.size() == 0) stall_cnt = 0;
      else begin
        e = q[0];
        if (stall_cnt > 0) begin
          chk("bubble_regwrite", {31'b0, regwrite_MEM_WB}, 32'h0);
          chk("bubble_memtoreg", {31'b0, memtoreg_MEM_WB}, 32'h0);
        end
        chk("dmem_req", {31'b0, dmem_req}, {31'b0, e.req});
        chk("dmem_we", {31'b0, dmem_we}, {31'b0, e.we});
        chk("dmem_addr", dmem_addr, e.addr);
        chk("dmem_wdata", dmem_wdata, e.wdata);
        chk("pcsrc", {31'b0, pcsrc}, {31'b0, e.pc});
        chk("branch_target", branch_target, e.tgt);
        if (stall_mem) stall_cnt++;
        else begin
          chk("stall_cycles", stall_cnt, e.stalls);
          stall_cnt = 0;
          @(posedge clk);
          #1;
          e = q.pop_front();
          chk("regwrite_MEM_WB", {31'b0, regwrite_MEM_WB}, {31'b0, e.rw});
          chk("memtoreg_MEM_WB", {31'b0, memtoreg_MEM_WB}, {31'b0, e.mtr});
          chk("rd_MEM_WB", {27'b0, rd_MEM_WB}, {27'b0, e.rd});
          chk("alu_result_MEM_WB", alu_result_MEM_WB, e.alu);
          chk("read_data_MEM_WB", read_data_MEM_WB, e.rdata);
          chk("mem_err", {31'b0, mem_err}, {31'b0, e.err});
        end
      end
    end
  end

  task automatic chk_reset_state(input string tag);
    chk({tag, "_regwrite"}, {31'b0, regwrite_MEM_WB}, 32'h0);
    chk({tag, "_memtoreg"}, {31'b0, memtoreg_MEM_WB}, 32'h0);
    chk({tag, "_rd"}, {27'b0, rd_MEM_WB}, 32'h0);
    chk({tag, "_alu"}, alu_result_MEM_WB, 32'h0);
    chk({tag, "_rdata"}, read_data_MEM_WB, 32'h0);
    chk({tag, "_mem_err"}, {31'b0, mem_err}, 32'h0);
  endtask

  initial begin
    int r, lat;
    logic mr, mw;
    memread_EX_MEM = 1; branch_EX_MEM = 1; z_flag_EX_MEM = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_dmem_req", {31'b0, dmem_req}, 32'h0);
    chk("rst_stall", {31'b0, stall_mem}, 32'h0);
    chk("rst_pcsrc", {31'b0, pcsrc}, 32'h0);
    chk_reset_state("rst");
    @(posedge clk);
    #1;
    reset = 0;
    issue(0, 0, 1, 0, 0, 0, 5'd5, 32'h1234, 32'h0, 32'h0, 32'h0, 0);
    issue(1, 0, 1, 1, 0, 0, 5'd7, 32'h40, 32'h0, 32'h0, 32'hDEADBEEF, 0);
    issue(0, 1, 0, 0, 0, 0, 5'd0, 32'h80, 32'hCAFE, 32'h0, 32'h0, 3);
    issue(1, 0, 1, 1, 0, 0, 5'd9, 32'h44, 32'h0, 32'h0, 32'h5555, 1000);
    issue(0, 0, 0, 0, 1, 1, 5'd0, 32'h0, 32'h0, 32'h200, 32'h0, 0);
    issue(0, 0, 0, 0, 1, 0, 5'd0, 32'h0, 32'h0, 32'h200, 32'h0, 0);
    issue(1, 1, 1, 0, 0, 0, 5'd3, 32'h88, 32'h77, 32'h0, 32'h9999, 2);
    issue(1, 0, 1, 1, 0, 0, 5'd4, 32'h90, 32'h0, 32'h0, 32'h1111, TO - 1);
    issue(1, 0, 1, 1, 0, 0, 5'd6, 32'h94, 32'h0, 32'h0, 32'h2222, TO);
    // Reset during WAIT: no scoreboard entry, checked directly.
    memread_EX_MEM = 1; memwrite_EX_MEM = 0; regwrite_EX_MEM = 1; memtoreg_EX_MEM = 1;
    branch_EX_MEM = 1; z_flag_EX_MEM = 1; dmem_ready = 0;
    repeat (2) begin @(posedge clk); #1; end
    reset = 1;
    @(negedge clk);
    chk("rstwait_dmem_req", {31'b0, dmem_req}, 32'h0);
    chk("rstwait_stall", {31'b0, stall_mem}, 32'h0);
    chk("rstwait_pcsrc", {31'b0, pcsrc}, 32'h0);
    @(posedge clk);
    #1;
    reset = 0;
    chk_reset_state("rstwait");
    m_rw = 0; m_mtr = 0; m_err = 0; m_rd = 0; m_alu = 0; m_rdata = 0;
    issue(1, 0, 1, 1, 0, 0, 5'd11, 32'h100, 32'h0, 32'h0, 32'hABCD0123, 2);
    for (int i = 0; i < 150; i++) begin
      r = $urandom_range(0, 9);
      lat = r < 4 ? 0 : r < 8 ? $urandom_range(1, 5) : r == 8 ? $urandom_range(TO - 2, TO - 1) : $urandom_range(TO, TO + 8);
      r = $urandom_range(0, 3);
      mr = r == 1 || r == 3;
      mw = r == 2 || r == 3;
      issue(mr, mw, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 5'($urandom),
            $urandom, $urandom, $urandom, $urandom, lat);
    end
    memread_EX_MEM = 0; memwrite_EX_MEM = 0; branch_EX_MEM = 0;
    for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
    #2;
    if (q.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain: %0d entries left, required 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule
